// File: rtl/dvp_pkg.sv
// Shared types and widths for the RGB565 to DVP transmitter.
// Holds the timing FSM state enumeration and bus width constants.
package dvp_pkg;

    localparam int RGB565_W = 16;
    localparam int RAW10_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_HBLANK,
        S_VFRONT
    } dvp_state_t;

endpackage

// File: rtl/rgb565_to_dvp_tx_if.sv
// Pixel stream handshake between a pixel source and the DVP transmitter.
// The source drives data/valid; the transmitter answers with ready.
interface rgb565_to_dvp_tx_if;
    import dvp_pkg::*;

    logic [RGB565_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/rgb565_to_raw10_luma.sv
// Combinational RGB565 to 10-bit luma-like RAW value.
// Channels widen by bit replication; green is weighted twice.
module rgb565_to_raw10_luma
    import dvp_pkg::*;
(
    input  logic [RGB565_W-1:0] i_rgb,
    output logic [RAW10_W-1:0]  o_raw
);

    localparam int SUM_W = RAW10_W + 2;

    logic [9:0]       w_r10;
    logic [9:0]       w_g10;
    logic [9:0]       w_b10;
    logic [SUM_W-1:0] w_sum;

    assign w_r10 = {i_rgb[15:11], i_rgb[15:11]};
    assign w_g10 = {i_rgb[10:5], i_rgb[10:7]};
    assign w_b10 = {i_rgb[4:0], i_rgb[4:0]};

    // Max sum is 1023 + 2046 + 1023 = 4092, so 12 bits never overflow.
    assign w_sum = {2'b00, w_r10}
                 + {1'b0, w_g10, 1'b0}
                 + {2'b00, w_b10};

    assign o_raw = w_sum[SUM_W-1:2];

endmodule

// File: rtl/rgb565_to_dvp_tx.sv
// DVP frame timing generator that streams RGB565 input as RAW10 pixels.
// Timing never stalls; missing input in an active slot is an underrun.
module rgb565_to_dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 40,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    rgb565_to_dvp_tx_if.slave    px_if,
    output logic [RAW10_W-1:0]   o_pixdata,
    output logic                 o_href,
    output logic                 o_vsync,
    output logic                 o_underrun,
    output logic                 o_frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int L_M1    = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
    localparam int L_M2    = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int L_MAX   = (L_M1 > L_M2) ? L_M1 : L_M2;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LW      = (L_MAX > 1) ? $clog2(L_MAX) : 1;

    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_BLK_LAST = HW'(H_BLANK - 1);
    localparam logic [HW-1:0] H_TOT_LAST = HW'(H_TOTAL - 1);
    localparam logic [LW-1:0] L_VS_LAST  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_VB_LAST  = LW'(V_BACK - 1);
    localparam logic [LW-1:0] L_ACT_LAST = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] L_VF_LAST  = LW'(V_FRONT - 1);

    dvp_state_t           r_state;
    dvp_state_t           w_state_nxt;
    logic [HW-1:0]        r_hcnt;
    logic [HW-1:0]        w_hcnt_nxt;
    logic [LW-1:0]        r_lcnt;
    logic [LW-1:0]        w_lcnt_nxt;
    logic                 w_frame_end;
    logic                 w_active;
    logic [RAW10_W-1:0]   w_luma;

    logic [RAW10_W-1:0]   r_pixdata;
    logic                 r_href;
    logic                 r_vsync;
    logic                 r_underrun;
    logic                 r_frame_done;

    rgb565_to_raw10_luma u_luma (
        .i_rgb (px_if.in_data),
        .o_raw (w_luma)
    );

    assign w_active       = (r_state == S_ACTIVE);
    assign px_if.in_ready = w_active;

    // State and position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    // Next state; the clock counter wraps on every line or state boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt + 1'b1;
        w_lcnt_nxt  = r_lcnt;
        w_frame_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_hcnt_nxt = '0;
                w_lcnt_nxt = '0;
                if (i_enable) w_state_nxt = S_VSYNC;
            end
            S_VSYNC: begin
                if (r_hcnt == H_TOT_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_lcnt == L_VS_LAST) begin
                        w_lcnt_nxt  = '0;
                        w_state_nxt = S_VBACK;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            S_VBACK: begin
                if (r_hcnt == H_TOT_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_lcnt == L_VB_LAST) begin
                        w_lcnt_nxt  = '0;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (r_hcnt == H_ACT_LAST) begin
                    w_hcnt_nxt  = '0;
                    w_state_nxt = S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (r_hcnt == H_BLK_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_lcnt == L_ACT_LAST) begin
                        w_lcnt_nxt  = '0;
                        w_state_nxt = S_VFRONT;
                    end else begin
                        w_lcnt_nxt  = r_lcnt + 1'b1;
                        w_state_nxt = S_ACTIVE;
                    end
                end
            end
            S_VFRONT: begin
                if (r_hcnt == H_TOT_LAST) begin
                    w_hcnt_nxt = '0;
                    if (r_lcnt == L_VF_LAST) begin
                        w_lcnt_nxt  = '0;
                        w_frame_end = 1'b1;
                        w_state_nxt = i_enable ? S_VSYNC : S_IDLE;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_hcnt_nxt  = '0;
                w_lcnt_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus outputs lag the state by one clock so all pins change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixdata    <= '0;
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_href       <= w_active;
            r_vsync      <= (r_state == S_VSYNC);
            r_underrun   <= w_active && !px_if.in_valid;
            r_pixdata    <= (w_active && px_if.in_valid) ? w_luma : '0;
            r_frame_done <= w_frame_end;
        end
    end

    assign o_pixdata    = r_pixdata;
    assign o_href       = r_href;
    assign o_vsync      = r_vsync;
    assign o_underrun   = r_underrun;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_rgb565_to_dvp_tx.sv
// Self-checking bench for rgb565_to_dvp_tx on a tiny 4x3 frame.
// Expected outputs come from a frame-position model of the timing.
module tb_rgb565_to_dvp_tx;

    localparam int H_ACTIVE    = 4;
    localparam int H_BLANK     = 2;
    localparam int V_ACTIVE    = 3;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;

    localparam int HT     = H_ACTIVE + H_BLANK;
    localparam int VS_END = VSYNC_LINES * HT;
    localparam int VB_END = VS_END + V_BACK * HT;
    localparam int AC_END = VB_END + V_ACTIVE * HT;
    localparam int FRAME  = AC_END + V_FRONT * HT;

    logic       clk;
    logic       rst;
    logic       i_enable;
    logic [9:0] o_pixdata;
    logic       o_href;
    logic       o_vsync;
    logic       o_underrun;
    logic       o_frame_done;

    rgb565_to_dvp_tx_if bus ();

    rgb565_to_dvp_tx #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .px_if        (bus.slave),
        .o_pixdata    (o_pixdata),
        .o_href       (o_href),
        .o_vsync      (o_vsync),
        .o_underrun   (o_underrun),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: frame position 0..FRAME-1 of the cycle about to be clocked.
    bit m_idle = 1'b1;
    int m_p    = 0;

    logic [15:0] pat [4] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_act();
        return !m_idle && m_p >= VB_END && m_p < AC_END
            && ((m_p - VB_END) % HT) < H_ACTIVE;
    endfunction

    function automatic int m_line();
        return (m_p - VB_END) / HT;
    endfunction

    function automatic int m_pix();
        return (m_p - VB_END) % HT;
    endfunction

    function automatic logic [9:0] ref_luma(input logic [15:0] d);
        int r, g, b, s;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        s = r * 33 + 2 * (g * 16 + g / 4) + b * 33;
        return 10'(s / 4);
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_pixdata"}, o_pixdata, 0);
        chk({tag, "_href"}, o_href, 0);
        chk({tag, "_vsync"}, o_vsync, 0);
        chk({tag, "_underrun"}, o_underrun, 0);
        chk({tag, "_frame_done"}, o_frame_done, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    // One clock: drive inputs, check ready, clock, check registered outputs.
    task automatic step(input bit en, input bit v, input logic [15:0] d);
        bit         a, e_vs, e_fd;
        logic [9:0] e_pix;
        i_enable     = en;
        bus.in_valid = v;
        bus.in_data  = d;
        a     = m_act();
        e_vs  = !m_idle && m_p < VS_END;
        e_fd  = !m_idle && m_p == FRAME - 1;
        e_pix = (a && v) ? ref_luma(d) : 10'd0;
        #1;
        chk("in_ready", bus.in_ready, a);
        @(posedge clk);
        #1;
        chk("href", o_href, a);
        chk("vsync", o_vsync, e_vs);
        chk("pixdata", o_pixdata, e_pix);
        chk("underrun", o_underrun, a && !v);
        chk("frame_done", o_frame_done, e_fd);
        if (m_idle) begin
            if (en) begin
                m_idle = 1'b0;
                m_p    = 0;
            end
        end else if (m_p == FRAME - 1) begin
            if (en) m_p = 0;
            else    m_idle = 1'b1;
        end else begin
            m_p++;
        end
    endtask

    initial begin
        bit          v;
        bit          dropped;
        logic [15:0] d;

        rst          = 1'b1;
        i_enable     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        chk_quiet("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset_held");
        rst = 1'b0;

        // Disabled: stays idle.
        repeat (3) step(1'b0, 1'b1, 16'($urandom));

        // Full frame, constant valid, known patterns on the first line.
        for (int c = 0; c < FRAME + 1; c++) begin
            d = 16'($urandom);
            if (m_act() && m_line() == 0) d = pat[m_pix()];
            step(1'b1, 1'b1, d);
        end

        // Back-to-back frame with random gaps; line 0 pixel 1 always missing.
        for (int c = 0; c < FRAME; c++) begin
            d = 16'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (m_act() && m_line() == 0) v = (m_pix() != 1);
            step(1'b1, v, d);
        end

        // Enable drops during line 2; the frame must still finish.
        dropped = 1'b0;
        for (int c = 0; c < FRAME + 24; c++) begin
            if (m_act() && m_line() == 1) dropped = 1'b1;
            step(!dropped, 1'b1, 16'($urandom));
        end
        chk("idle_after_drop", m_idle, 1);

        // Start again, then reset in the middle of the first active line.
        for (int c = 0; c < FRAME; c++) begin
            if (m_act() && m_line() == 0 && m_pix() == 2) break;
            step(1'b1, 1'b1, 16'($urandom));
        end
        chk("reached_active", bus.in_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("reset_mid");
        m_idle = 1'b1;
        m_p    = 0;
        @(posedge clk);
        #1;
        chk_quiet("reset_mid_held");
        rst = 1'b0;

        // Restart after reset: a complete frame from a full vsync.
        for (int c = 0; c < FRAME + 6; c++) begin
            step(1'b1, ($urandom_range(0, 4) != 0), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb565_to_dvp_tx.md
RGB565_TO_DVP_TX -- requirements
Module: rgb565_to_dvp_tx

Interface
REQ-001 Parameter H_ACTIVE, default 160, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 120, active lines per frame.
REQ-003 Parameter H_BLANK, default 40, blanking clocks after each active line.
REQ-004 Parameter VSYNC_LINES, default 4, vsync pulse length in line periods.
REQ-005 Parameter V_BACK, default 2, blank lines between vsync and first active line.
REQ-006 Parameter V_FRONT, default 2, blank lines after last active line.
REQ-007 clk  input  1  pixel clock; all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 enable  input  1  frame generation enable, sampled only at frame boundary.
REQ-010 in_data  input  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-011 in_valid  input  1  in_data valid.
REQ-012 in_ready  output  1  module accepts in_data this cycle.
REQ-013 pixdata  output  10  RAW10 pixel for DVP bus.
REQ-014 href  output  1  high during active pixels of a line.
REQ-015 vsync  output  1  high during vsync period.
REQ-016 underrun  output  1  one-cycle pulse: active slot with no valid input.
REQ-017 frame_done  output  1  one-cycle pulse at end of front porch.

Function
REQ-018 Line period H_TOTAL = H_ACTIVE + H_BLANK clocks; all vertical intervals are whole line periods.
REQ-019 FSM states IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-020 IDLE -> VSYNC when enable=1; otherwise remain IDLE.
REQ-021 VSYNC lasts VSYNC_LINES*H_TOTAL clocks, then VBACK for V_BACK*H_TOTAL clocks, then ACTIVE.
REQ-022 ACTIVE lasts H_ACTIVE clocks then HBLANK for H_BLANK clocks; after HBLANK go ACTIVE if lines remain, else VFRONT.
REQ-023 VFRONT lasts V_FRONT*H_TOTAL clocks; at its last cycle pulse frame_done and go VSYNC if enable=1, else IDLE.
REQ-024 enable deasserted mid-frame has no effect until the frame completes.
REQ-025 in_ready = 1 exactly in ACTIVE state cycles; combinational from state.
REQ-026 Timing never stalls: an ACTIVE cycle with in_valid=0 outputs pixdata=0 and pulses underrun.
REQ-027 Outputs registered: state/acceptance in cycle t drives href, vsync, pixdata in cycle t+1.
REQ-028 vsync=1 for every cycle of VSYNC (delayed one clock); href=1 for every ACTIVE cycle (delayed one clock).
REQ-029 pixdata = 0 whenever href=0.
REQ-030 Conversion: R10={R,R}, G10={G,G[5:2]}, B10={B,B}; sum = R10 + 2*G10 + B10 (12 bits, no overflow); pixdata = sum[11:2] (truncate).
REQ-031 Horizontal counter 0..H_TOTAL-1 and line counter sized by $clog2 of largest count; wrap to 0 at state transitions.
REQ-032 underrun and frame_done registered, aligned with the corresponding href/pixdata cycle.

Reset
REQ-033 rst asserted: state IDLE, counters 0, pixdata=0, href=0, vsync=0, underrun=0, frame_done=0, in_ready=0.
REQ-034 rst mid-frame aborts immediately; after release, a new frame starts from VSYNC only when enable=1.

Structure
REQ-035 Shared package dvp_pkg holds the state enumeration and RAW10/RGB565 width constants.
REQ-036 Conversion (REQ-030) is sub-module rgb565_to_raw10_luma, purely combinational; timing FSM stays in the top.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1)
REQ-037 enable=1, in_valid=1 constant -> vsync high 6 clocks, 6 clocks blank, then 3 href pulses of 4 clocks separated by 2 low clocks, frame_done after 6 more clocks; frame period 36 clocks.
REQ-038 in_data 16'hFFFF, 16'h0000, 16'hF800, 16'h07E0 in one line -> pixdata 1023, 0, 255, 511 on consecutive href cycles.
REQ-039 in_valid low on 2nd pixel of line 1 -> that pixdata=0, underrun pulse on same cycle, href width unchanged.
REQ-040 enable dropped during line 2 -> frame completes, frame_done pulses, FSM returns IDLE, vsync stays low.
REQ-041 rst asserted during ACTIVE -> all outputs 0 asynchronously; after release with enable=1, next output activity is a full 6-clock vsync.
